// File: rtl/fifo_rd_drain.sv
// Read-side drain engine for an async FIFO: pops words into a 2-entry skid
// buffer, presents them on a valid/ready port and supports a discard-all flush.
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [DATA_WIDTH-1:0] rData,
    input  logic                  rEmpty,
    output logic                  rinc,
    input  logic                  rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic                  r_head;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_flush_done;
    logic [CNT_WIDTH-1:0]  r_rd_count;

    logic                  w_xfer;
    logic                  w_capture;
    logic                  w_wr_ptr;
    logic                  w_flush_exit;
    logic [1:0]            w_budget;

    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_buf[r_head];
    assign flush_done = r_flush_done;
    assign rd_count   = r_rd_count;
    assign busy       = (r_state != ST_IDLE) | r_inflight;

    assign w_xfer    = out_valid & out_ready;
    assign w_capture = r_inflight & (r_state != ST_FLUSH);
    assign w_wr_ptr  = r_head ^ r_occ[0];
    // Slots that will be committed after this edge; xfer implies occ>0, so no underflow.
    assign w_budget  = r_occ + {1'b0, r_inflight} - {1'b0, w_xfer};

    always_comb begin
        w_state_next = r_state;
        rinc         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rd_en) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                rinc = !rEmpty && (w_budget < 2'd2);
                if (!rd_en) w_state_next = ST_IDLE;
            end
            ST_FLUSH: begin
                rinc = !rEmpty;
                if (rEmpty && !r_inflight) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) w_state_next = ST_FLUSH;
    end

    assign w_flush_exit = (r_state == ST_FLUSH) && (w_state_next == ST_IDLE);

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            r_state      <= ST_IDLE;
            r_inflight   <= 1'b0;
            r_occ        <= 2'd0;
            r_head       <= 1'b0;
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
            r_flush_done <= 1'b0;
            r_rd_count   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_inflight   <= rinc;
            r_flush_done <= w_flush_exit;
            if (w_xfer) r_rd_count <= r_rd_count + 1'b1;
            // A flush request empties the buffer and drops any word landing this edge.
            if (flush) begin
                r_occ  <= 2'd0;
                r_head <= 1'b0;
            end else begin
                if (w_capture) r_buf[w_wr_ptr] <= rData;
                r_occ <= r_occ + {1'b0, w_capture} - {1'b0, w_xfer};
                if (w_xfer) r_head <= ~r_head;
            end
        end
    end

endmodule
